// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//
// Iterative unsigned multiply/divide execution stage. It takes its operands
// from the RegisterFile read ports and returns one write-back (data,
// destination, active-low write enable) to the RegisterFile write port.
// The unit performs one radix-2 step per clock.
//
// Parameters
//   DataWidth   operand/result width; also the number of iteration steps
//   SelectSize  register-select width (matches RegisterFile)
//
// Ports
//   clk_i        system clock, rising edge
//   reset_i      synchronous active-high reset
//   start_i      operation request, accepted only while busy_o is low
//   op_i         0 = multiply (a*b), 1 = divide (a/b)
//   src1_i       operand a (multiplicand / dividend)
//   src2_i       operand b (multiplier / divisor)
//   dst_i        destination register for the result
//   busy_o       high while an operation is in RUN or WB
//   done_o       one-cycle pulse in WB
//   result_o     low product word / quotient
//   reg_we_o     active-low RegisterFile write enable, low only in WB
//   reg_dst_o    destination register latched at accept
//   div_zero_o   last accepted divide had b == 0 (cleared by the next accept)
//   hi_o         upper product word / remainder (MULDIV_HIGH_WORD_EN only)
//
// Optional feature macro: MULDIV_HIGH_WORD_EN adds the hi_o output.
// ---------------------------------------------------------------------------
module mul_div_unit #(
    parameter int DataWidth  = 16,
    parameter int SelectSize = 3
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic                  op_i,
    input  logic [DataWidth-1:0]  src1_i,
    input  logic [DataWidth-1:0]  src2_i,
    input  logic [SelectSize-1:0] dst_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DataWidth-1:0]  result_o,
    output logic                  reg_we_o,
    output logic [SelectSize-1:0] reg_dst_o,
    output logic                  div_zero_o
`ifdef MULDIV_HIGH_WORD_EN
    ,
    output logic [DataWidth-1:0]  hi_o
`endif
);

    localparam int CntWidth = $clog2(DataWidth + 1);
    localparam logic [CntWidth-1:0] CntLoad = CntWidth'(DataWidth);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StWb   = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [CntWidth-1:0]    count_q, count_d;
    // Shared working register: multiply {acc_hi, multiplier/acc_lo},
    // divide {remainder, dividend/quotient}.
    logic [2*DataWidth-1:0] work_q, work_d;
    // Multiply keeps the multiplicand here, divide keeps the divisor.
    logic [DataWidth-1:0]   operand_q, operand_d;
    logic                   op_q, op_d;
    logic [DataWidth-1:0]   result_q, result_d;
    logic [SelectSize-1:0]  reg_dst_q, reg_dst_d;
    logic                   div_zero_q, div_zero_d;
`ifdef MULDIV_HIGH_WORD_EN
    logic [DataWidth-1:0]   hi_q, hi_d;
`endif

    logic [DataWidth:0]     mul_sum;
    logic [2*DataWidth-1:0] mul_next;
    logic [DataWidth:0]     div_shift;
    logic                   div_ge;
    logic [DataWidth-1:0]   div_sub;
    logic [2*DataWidth-1:0] div_next;

    // One radix-2 step of each algorithm, computed from the working register.
    // Multiply adds the multiplicand into the upper half when the current
    // multiplier LSB is set, then shifts the whole accumulator right.
    // Restoring divide shifts the next dividend bit into the remainder and
    // subtracts the divisor when it fits; the subtraction is done modulo
    // 2^DataWidth because a successful subtract always fits in DataWidth bits.
    always_comb begin
        mul_sum   = {1'b0, work_q[2*DataWidth-1:DataWidth]} + {1'b0, operand_q};
        mul_next  = work_q[0] ? {mul_sum, work_q[DataWidth-1:1]}
                              : {1'b0, work_q[2*DataWidth-1:1]};
        div_shift = {work_q[2*DataWidth-1:DataWidth], work_q[DataWidth-1]};
        div_ge    = div_shift >= {1'b0, operand_q};
        div_sub   = div_shift[DataWidth-1:0] - operand_q;
        div_next  = div_ge ? {div_sub, work_q[DataWidth-2:0], 1'b1}
                           : {div_shift[DataWidth-1:0], work_q[DataWidth-2:0], 1'b0};
    end

    // Control FSM and next-state for every register.
    // RUN performs DataWidth steps and then spends one more edge loading the
    // result registers on the way into WB. A divide by zero enters RUN with a
    // zero count, so it skips every step and takes only that load edge.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        work_d     = work_q;
        operand_d  = operand_q;
        op_d       = op_q;
        result_d   = result_q;
        reg_dst_d  = reg_dst_q;
        div_zero_d = div_zero_q;
`ifdef MULDIV_HIGH_WORD_EN
        hi_d       = hi_q;
`endif
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d    = StRun;
                    count_d    = CntLoad;
                    op_d       = op_i;
                    reg_dst_d  = dst_i;
                    div_zero_d = 1'b0;
                    if (op_i) begin
                        operand_d = src2_i;
                        work_d    = {{DataWidth{1'b0}}, src1_i};
                        if (src2_i == '0) begin
                            // Quotient all ones, remainder = dividend.
                            div_zero_d = 1'b1;
                            count_d    = '0;
                            work_d     = {src1_i, {DataWidth{1'b1}}};
                        end
                    end else begin
                        operand_d = src1_i;
                        work_d    = {{DataWidth{1'b0}}, src2_i};
                    end
                end
            end
            StRun: begin
                if (count_q != '0) begin
                    work_d  = op_q ? div_next : mul_next;
                    count_d = count_q - CntWidth'(1);
                end else begin
                    state_d  = StWb;
                    result_d = work_q[DataWidth-1:0];
`ifdef MULDIV_HIGH_WORD_EN
                    hi_d     = work_q[2*DataWidth-1:DataWidth];
`endif
                end
            end
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            count_q    <= '0;
            work_q     <= '0;
            operand_q  <= '0;
            op_q       <= 1'b0;
            result_q   <= '0;
            reg_dst_q  <= '0;
            div_zero_q <= 1'b0;
`ifdef MULDIV_HIGH_WORD_EN
            hi_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            work_q     <= work_d;
            operand_q  <= operand_d;
            op_q       <= op_d;
            result_q   <= result_d;
            reg_dst_q  <= reg_dst_d;
            div_zero_q <= div_zero_d;
`ifdef MULDIV_HIGH_WORD_EN
            hi_q       <= hi_d;
`endif
        end
    end

    assign busy_o     = (state_q != StIdle);
    assign done_o     = (state_q == StWb);
    assign reg_we_o   = (state_q != StWb);
    assign result_o   = result_q;
    assign reg_dst_o  = reg_dst_q;
    assign div_zero_o = div_zero_q;
`ifdef MULDIV_HIGH_WORD_EN
    assign hi_o       = hi_q;
`endif

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
//
// Self-checking bench for mul_div_unit. A table of directed operations with
// hand-computed results is run back to back, followed by hand-written
// sequences for busy-time start pulses and a reset in the middle of RUN.
// A small RegisterFile model captures each write-back. Define
// MULDIV_HIGH_WORD_EN to also check hi_o.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic        op_i;
    logic [15:0] src1_i;
    logic [15:0] src2_i;
    logic [2:0]  dst_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] result_o;
    logic        reg_we_o;
    logic [2:0]  reg_dst_o;
    logic        div_zero_o;
`ifdef MULDIV_HIGH_WORD_EN
    logic [15:0] hi_o;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int we_pulses = 0;
    int we_illegal = 0;
    int done_pulses = 0;
    logic [15:0] rf [8];

    typedef struct {
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  dst;
        logic [15:0] exp_res;
        logic [15:0] exp_hi;
        logic        exp_dz;
        int          exp_lat;
    } vec_t;

    vec_t vecs [9];

    mul_div_unit #(.DataWidth(16), .SelectSize(3)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .op_i       (op_i),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
        .dst_i      (dst_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .reg_we_o   (reg_we_o),
        .reg_dst_o  (reg_dst_o),
        .div_zero_o (div_zero_o)
`ifdef MULDIV_HIGH_WORD_EN
        ,
        .hi_o       (hi_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // RegisterFile model: writes on the rising edge when the enable is low.
    always @(posedge clk_i) begin
        if (!reg_we_o) rf[reg_dst_o] <= result_o;
    end

    // Write-enable monitor, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (!reg_we_o) we_pulses++;
        if (done_o) done_pulses++;
        if ((reg_we_o == done_o) || (!reg_we_o && !busy_o)) we_illegal++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issues one start (sampled at the next rising edge), then scrambles the
    // operand inputs and waits for done_o. lat = edges after the accept edge.
    task automatic applyStimulus(input logic op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [2:0] dst, output int lat);
        @(negedge clk_i);
        start_i = 1'b1; op_i = op; src1_i = a; src2_i = b; dst_i = dst;
        @(posedge clk_i); #1;
        start_i = 1'b0; src1_i = ~a; src2_i = ~b; dst_i = ~dst; op_i = ~op;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk_i); #1;
            if (done_o) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int we_before;
        int done_before;

        vecs[0] = '{1'b0, 16'h00A0, 16'h000A, 3'd1, 16'h0640, 16'h0000, 1'b0, 17};
        vecs[1] = '{1'b0, 16'h1234, 16'h0100, 3'd2, 16'h3400, 16'h0012, 1'b0, 17};
        vecs[2] = '{1'b1, 16'h00A0, 16'h000A, 3'd3, 16'h0010, 16'h0000, 1'b0, 17};
        vecs[3] = '{1'b1, 16'h0123, 16'h0000, 3'd4, 16'hFFFF, 16'h0123, 1'b1, 1};
        vecs[4] = '{1'b0, 16'hFFFF, 16'hFFFF, 3'd5, 16'h0001, 16'hFFFE, 1'b0, 17};
        vecs[5] = '{1'b1, 16'hFFFF, 16'h0007, 3'd6, 16'h2492, 16'h0001, 1'b0, 17};
        vecs[6] = '{1'b1, 16'h0005, 16'h0009, 3'd7, 16'h0000, 16'h0005, 1'b0, 17};
        vecs[7] = '{1'b0, 16'h0000, 16'h1234, 3'd1, 16'h0000, 16'h0000, 1'b0, 17};
        vecs[8] = '{1'b1, 16'h8000, 16'h8000, 3'd2, 16'h0001, 16'h0000, 1'b0, 17};

        for (int r = 0; r < 8; r++) rf[r] = 16'hDEAD;
        reset_i = 1'b1; start_i = 1'b0; op_i = 1'b0;
        src1_i = '0; src2_i = '0; dst_i = '0;

        // Reset held, then three idle cycles.
        repeat (3) @(posedge clk_i);
        #1 reset_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("reset_busy", 32'(busy_o), 32'd0);
        checkOutput("reset_done", 32'(done_o), 32'd0);
        checkOutput("reset_we", 32'(reg_we_o), 32'd1);
        checkOutput("reset_result", 32'(result_o), 32'h0000);
        checkOutput("reset_dst", 32'(reg_dst_o), 32'd0);
        checkOutput("reset_dz", 32'(div_zero_o), 32'd0);
        checkOutput("reset_we_pulses", 32'(we_pulses), 32'd0);

        // Table-driven operations, run back to back.
        for (int i = 0; i < 9; i++) begin
            we_before = we_pulses;
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dst, lat);
            checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            checkOutput($sformatf("v%0d_result", i), 32'(result_o), 32'(vecs[i].exp_res));
            checkOutput($sformatf("v%0d_dst", i), 32'(reg_dst_o), 32'(vecs[i].dst));
            checkOutput($sformatf("v%0d_div_zero", i), 32'(div_zero_o), 32'(vecs[i].exp_dz));
            checkOutput($sformatf("v%0d_we_low", i), 32'(reg_we_o), 32'd0);
`ifdef MULDIV_HIGH_WORD_EN
            checkOutput($sformatf("v%0d_hi", i), 32'(hi_o), 32'(vecs[i].exp_hi));
`endif
            @(posedge clk_i); #1;
            checkOutput($sformatf("v%0d_idle_busy", i), 32'(busy_o), 32'd0);
            checkOutput($sformatf("v%0d_held_result", i), 32'(result_o), 32'(vecs[i].exp_res));
            checkOutput($sformatf("v%0d_we_count", i), 32'(we_pulses - we_before), 32'd1);
            checkOutput($sformatf("v%0d_regfile", i), 32'(rf[vecs[i].dst]), 32'(vecs[i].exp_res));
        end

        // start_i pulsed during RUN step 5 with other operands is ignored.
        we_before = we_pulses;
        @(negedge clk_i);
        start_i = 1'b1; op_i = 1'b0; src1_i = 16'h00A0; src2_i = 16'h000A; dst_i = 3'd1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        start_i = 1'b1; op_i = 1'b1; src1_i = 16'h0001; src2_i = 16'h0001; dst_i = 3'd7;
        @(negedge clk_i);
        start_i = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk_i); #1;
            if (done_o) begin
                lat = k;
                break;
            end
        end
        checkOutput("busy_start_done_seen", 32'(lat > 0), 32'd1);
        checkOutput("busy_start_result", 32'(result_o), 32'h0640);
        checkOutput("busy_start_dst", 32'(reg_dst_o), 32'd1);
        repeat (20) @(posedge clk_i);
        #1;
        checkOutput("busy_start_we_count", 32'(we_pulses - we_before), 32'd1);
        checkOutput("busy_start_idle", 32'(busy_o), 32'd0);

        // Reset at RUN step 8: straight back to IDLE, no write-back.
        we_before = we_pulses;
        done_before = done_pulses;
        @(negedge clk_i);
        start_i = 1'b1; op_i = 1'b0; src1_i = 16'h1234; src2_i = 16'h0100; dst_i = 3'd2;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (7) @(negedge clk_i);
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        checkOutput("midreset_busy", 32'(busy_o), 32'd0);
        checkOutput("midreset_result", 32'(result_o), 32'h0000);
        checkOutput("midreset_dst", 32'(reg_dst_o), 32'd0);
        reset_i = 1'b0;
        repeat (25) @(posedge clk_i);
        #1;
        checkOutput("midreset_we_count", 32'(we_pulses - we_before), 32'd0);
        checkOutput("midreset_done_count", 32'(done_pulses - done_before), 32'd0);

        // New operation after the aborted one completes normally.
        we_before = we_pulses;
        applyStimulus(1'b0, 16'h0003, 16'h0005, 3'd3, lat);
        checkOutput("post_reset_latency", 32'(lat), 32'd17);
        checkOutput("post_reset_result", 32'(result_o), 32'h000F);
        checkOutput("post_reset_dst", 32'(reg_dst_o), 32'd3);
        @(posedge clk_i); #1;
        checkOutput("post_reset_we_count", 32'(we_pulses - we_before), 32'd1);
        checkOutput("post_reset_regfile", 32'(rf[3]), 32'h000F);

        checkOutput("we_only_in_wb", 32'(we_illegal), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
